ram_1p_host_adapter: RTL and testbench

Upstream front-end for the single-port generic RAM. Accepts word requests on a valid/ready host channel, expands byte enables into the RAM's per-bit write mask, and drives the RAM's req/write/addr/wdata/wmask inputs. Captures one-cycle-late read data, plus a write acknowledge for every write, into an in-order response FIFO with valid/ready backpressure. The RAM itself has no backpressure, so the adapter admits a request only when it has a response slot reserved for it.

---
 rtl/ram_adapter_pkg.sv | 37 +++
 rtl/ram_adapter_rsp_fifo.sv | 72 +++++++
 rtl/ram_1p_host_adapter.sv | 153 +++++++++++++++
 tb/tb_ram_1p_host_adapter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_adapter_pkg
// Description : Shared types and helpers for ram_1p_host_adapter: response
//               kind enum, response record and byte-enable expansion.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_adapter_pkg;

   // Data width carried by a response record; the adapter's Width must match.
   localparam int unsigned DataWidth = 32;

   // Widest byte-enable vector the mask expansion handles.
   localparam int unsigned MaxBeW = 64;

   typedef enum logic [1:0] {
      RSP_READ  = 2'd0,
      RSP_WRITE = 2'd1,
      RSP_ERR   = 2'd2
   } rsp_kind_e;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic                 err;
   } rsp_t;

   // Bit i of the mask follows byte enable i/8; callers truncate to their width.
   function automatic logic [MaxBeW*8-1:0] expand_be(input logic [MaxBeW-1:0] be);
      logic [MaxBeW*8-1:0] mask;
      for (int i = 0; i < MaxBeW*8; i++) begin
         mask[i] = be[i/8];
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_adapter_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ram_adapter_rsp_fifo
// Description : Synchronous response FIFO, RspDepth entries of Width+1 bits,
//               with occupancy count, full and empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_adapter_rsp_fifo #(
   parameter  int unsigned Width    = 32,
   parameter  int unsigned RspDepth = 2,
   localparam int unsigned CntW     = $clog2(RspDepth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  logic [Width:0]  wdata_i,
   input  logic            pop_i,
   output logic [Width:0]  rdata_o,
   output logic [CntW-1:0] count_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

   logic [Width:0]  mem_q [RspDepth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Pointer and occupancy next-state; simultaneous push and pop keeps count.
   always_comb begin
      wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Storage and pointers; reset clears entries so the head reads zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RspDepth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CntW'(RspDepth));
   assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ram_1p_host_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ram_1p_host_adapter
// Description : Valid/ready host front-end for a single-port RAM with one
//               cycle read latency. Requests are admitted only when a response
//               slot is reserved; responses return in order through a FIFO.
//               Optional macro RAM_ADAPTER_RANGE_CHECK_EN turns addresses at or
//               above Depth into error responses instead of aliasing.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1p_host_adapter
   import ram_adapter_pkg::*;
#(
   parameter int unsigned Width    = DataWidth,
   parameter int unsigned Depth    = 128,
   parameter int unsigned Aw       = $clog2(Depth),
   parameter int unsigned HostAw   = 16,
   parameter int unsigned RspDepth = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [HostAw-1:0]   req_addr_i,
   input  logic [Width-1:0]    req_wdata_i,
   input  logic [Width/8-1:0]  req_be_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [Width-1:0]    rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                ram_req_o,
   output logic                ram_write_o,
   output logic [Aw-1:0]       ram_addr_o,
   output logic [Width-1:0]    ram_wdata_o,
   output logic [Width-1:0]    ram_wmask_o,
   input  logic                ram_rvalid_i,
   input  logic [Width-1:0]    ram_rdata_i
);

   localparam int unsigned CntW  = $clog2(RspDepth + 1);
   localparam int unsigned UsedW = CntW + 1;

   logic             accept;
   logic             in_range;
   logic             stage_valid_q, stage_valid_d;
   rsp_kind_e        stage_kind_q, stage_kind_d;
   rsp_t             push_rsp;
   rsp_t             head_rsp;
   logic [Width:0]   head_raw;
   logic             pop;
   logic [CntW-1:0]  fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [UsedW-1:0] used;

`ifdef RAM_ADAPTER_RANGE_CHECK_EN
   // One extra bit keeps the compare exact even when Depth == 2**HostAw.
   localparam logic [HostAw:0] DepthExt = (HostAw + 1)'(Depth);
   assign in_range  = ({1'b0, req_addr_i} < DepthExt);
   assign rsp_err_o = head_rsp.err;
`else
   logic unused_err;
   assign in_range   = 1'b1;
   assign rsp_err_o  = 1'b0;
   assign unused_err = head_rsp.err;
`endif

   // Host address bits above the RAM address only matter to the range check.
   if (HostAw > Aw) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr_i[HostAw-1:Aw];
   end

   // Credit: slots held by the FIFO and the stage, minus one freed by this pop.
   assign pop         = !fifo_empty && rsp_ready_i;
   assign used        = UsedW'(fifo_count) + UsedW'(stage_valid_q);
   assign req_ready_o = rst_ni && ((used - UsedW'(pop)) < UsedW'(RspDepth));
   assign accept      = req_valid_i && req_ready_o;

   // RAM request path is purely combinational from the host channel.
   assign ram_req_o   = accept && in_range;
   assign ram_write_o = req_write_i;
   assign ram_addr_o  = req_addr_i[Aw-1:0];
   assign ram_wdata_o = req_wdata_i;
   assign ram_wmask_o = Width'(expand_be(MaxBeW'(req_be_i)));

   // Classify the accepted request so the stage knows what to push next cycle.
   always_comb begin
      stage_valid_d = accept;
      stage_kind_d  = stage_kind_q;
      if (accept) begin
         if (!in_range) begin
            stage_kind_d = RSP_ERR;
         end else if (req_write_i) begin
            stage_kind_d = RSP_WRITE;
         end else begin
            stage_kind_d = RSP_READ;
         end
      end
   end

   // One-entry stage aligning the request with the RAM's late read data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid_q <= 1'b0;
         stage_kind_q  <= RSP_READ;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_kind_q  <= stage_kind_d;
      end
   end

   // Build the response record; only reads carry data.
   always_comb begin
      push_rsp.rdata = '0;
      push_rsp.err   = 1'b0;
      case (stage_kind_q)
         RSP_READ: push_rsp.rdata = ram_rdata_i;
         RSP_ERR:  push_rsp.err   = 1'b1;
         default:  ;
      endcase
   end

   ram_adapter_rsp_fifo #(
      .Width    (Width),
      .RspDepth (RspDepth)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (stage_valid_q),
      .wdata_i (push_rsp),
      .pop_i   (pop),
      .rdata_o (head_raw),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_rsp    = rsp_t'(head_raw);
   assign rsp_valid_o = !fifo_empty;
   assign rsp_rdata_o = head_rsp.rdata;

   // The RAM must return data for every read the stage is retiring.
   a_read_has_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (stage_valid_q && stage_kind_q == RSP_READ) |-> ram_rvalid_i);

   // Credit accounting guarantees the FIFO is never pushed while full.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (stage_valid_q && fifo_full) |-> pop);

endmodule
`default_nettype wire

// File: tb/tb_ram_1p_host_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_1p_host_adapter
// Description : Directed bench for ram_1p_host_adapter with a behavioural
//               one-cycle-latency RAM attached to the adapter's RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_1p_host_adapter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ram_req, ram_write, ram_rvalid;
   logic [6:0]  ram_addr;
   logic [31:0] ram_wdata, ram_wmask, ram_rdata;

   logic [31:0] mem [128];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ram_1p_host_adapter #(
      .Width(32), .Depth(128), .HostAw(16), .RspDepth(2)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
      .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
   );

   // Behavioural single-port RAM: masked write, read data one cycle later.
   always @(posedge clk) begin
      ram_rvalid <= ram_req && !ram_write;
      if (ram_req) begin
         if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
         else           ram_rdata <= mem[ram_addr];
      end
   end

   task automatic drive_req(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
   endtask

   task automatic drive_idle();
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b1;
      drive_req(1'b0, 16'd0, 32'd0, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL reset_ram_req: got %b want 0", ram_req); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      vectors++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", rsp_rdata, rsp_err); end
      next_cycle();
      drive_idle(); rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", req_ready); end
      next_cycle();
   endtask

   task automatic test_write_read();
      drive_req(1'b1, 16'd5, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      vectors++; if (req_ready !== 1'b1 || ram_req !== 1'b1 || ram_write !== 1'b1) begin miscompares++; $display("FAIL wr_strobes: got ready %b req %b write %b want 1 1 1", req_ready, ram_req, ram_write); end
      vectors++; if (ram_addr !== 7'd5 || ram_wdata !== 32'hDEADBEEF || ram_wmask !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL wr_payload: got %h %h %h want 05 deadbeef ffffffff", ram_addr, ram_wdata, ram_wmask); end
      next_cycle();
      drive_req(1'b0, 16'd5, 32'h0, 4'h0);
      @(negedge clk);
      vectors++; if (ram_req !== 1'b1 || ram_write !== 1'b0) begin miscompares++; $display("FAIL rd_strobes: got req %b write %b want 1 0", ram_req, ram_write); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_early: got valid %b want 0", rsp_valid); end
      next_cycle();
      drive_idle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL wr_rsp: got %b %h %b want 1 00000000 0", rsp_valid, rsp_rdata, rsp_err); end
      next_cycle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rd_rsp: got %b %h %b want 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_err); end
      next_cycle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL drained: got valid %b want 0", rsp_valid); end
      next_cycle();
      // Lone read from idle: nothing at t+1, data at t+2.
      drive_req(1'b0, 16'd5, 32'h0, 4'h0);
      next_cycle();
      drive_idle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lat_t1: got valid %b want 0", rsp_valid); end
      next_cycle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lat_t2: got %b %h want 1 deadbeef", rsp_valid, rsp_rdata); end
      next_cycle();
   endtask

   task automatic test_byte_enable();
      drive_req(1'b1, 16'd3, 32'hFFFFFFFF, 4'hF);
      next_cycle();
      drive_req(1'b1, 16'd3, 32'h11223344, 4'b0101);
      @(negedge clk);
      vectors++; if (ram_wmask !== 32'h00FF00FF) begin miscompares++; $display("FAIL be_mask: got %h want 00ff00ff", ram_wmask); end
      next_cycle();
      drive_req(1'b0, 16'd3, 32'h0, 4'h0);
      next_cycle();
      drive_idle();
      next_cycle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFF22FF44) begin miscompares++; $display("FAIL be_read: got %b %h want 1 ff22ff44", rsp_valid, rsp_rdata); end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_fill();
      int nrsp = 0;
      for (int c = 0; c < 20; c++) begin
         if (c < 16) drive_req(1'b1, 16'(c), 32'hCAFE0000 + 32'(c), 4'hF);
         else        drive_idle();
         @(negedge clk);
         if (c < 16) begin
            vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d]: got %b want 1", c, req_ready); end
         end
         if (rsp_valid && rsp_ready) begin
            nrsp++;
            vectors++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL fill_rsp: got %h %b want 0 0", rsp_rdata, rsp_err); end
         end
         next_cycle();
      end
      vectors++; if (nrsp != 16) begin miscompares++; $display("FAIL fill_count: got %0d want 16", nrsp); end
   endtask

   task automatic test_stream();
      int k = 0, ridx = 0, cyc = 0;
      while (ridx < 16 && cyc < 40) begin
         if (k < 16) drive_req(1'b0, 16'(k), 32'h0, 4'h0);
         else        drive_idle();
         @(negedge clk);
         if (k < 16) begin
            vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d]: got %b want 1", k, req_ready); end
            if (req_ready) k++;
         end
         if (rsp_valid && rsp_ready) begin
            vectors++; if (rsp_rdata !== 32'hCAFE0000 + 32'(ridx)) begin miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", ridx, rsp_rdata, 32'hCAFE0000 + 32'(ridx)); end
            ridx++;
         end
         next_cycle(); cyc++;
      end
      drive_idle();
      vectors++; if (ridx != 16) begin miscompares++; $display("FAIL stream_count: got %0d want 16", ridx); end
   endtask

   task automatic test_backpressure();
      int k = 0, acc = 0, ridx = 0, cyc = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         drive_req(1'b0, 16'(k), 32'h0, 4'h0);
         @(negedge clk);
         if (req_ready) begin acc++; k++; end
         next_cycle();
      end
      vectors++; if (acc != 2) begin miscompares++; $display("FAIL bp_accepts: got %0d want 2", acc); end
      @(negedge clk);
      vectors++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stalled: got ready %b valid %b want 0 1", req_ready, rsp_valid); end
      next_cycle();
      rsp_ready = 1'b1;
      while (ridx < 8 && cyc < 30) begin
         if (k < 8) drive_req(1'b0, 16'(k), 32'h0, 4'h0);
         else       drive_idle();
         @(negedge clk);
         if (k < 8) begin
            vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_resume_ready[%0d]: got %b want 1", k, req_ready); end
            if (req_ready) k++;
         end
         if (rsp_valid && rsp_ready) begin
            vectors++; if (rsp_rdata !== 32'hCAFE0000 + 32'(ridx)) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", ridx, rsp_rdata, 32'hCAFE0000 + 32'(ridx)); end
            ridx++;
         end
         next_cycle(); cyc++;
      end
      drive_idle();
      vectors++; if (ridx != 8) begin miscompares++; $display("FAIL bp_count: got %0d want 8", ridx); end
   endtask

   task automatic test_range();
      logic        exp_req;
      logic [31:0] exp_data;
      logic        exp_err;
`ifdef RAM_ADAPTER_RANGE_CHECK_EN
      exp_req = 1'b0; exp_data = 32'h0; exp_err = 1'b1;
`else
      exp_req = 1'b1; exp_data = 32'hCAFE0000; exp_err = 1'b0;
`endif
      drive_req(1'b0, 16'd128, 32'h0, 4'h0);
      @(negedge clk);
      vectors++; if (req_ready !== 1'b1 || ram_req !== exp_req) begin miscompares++; $display("FAIL range_req: got ready %b ram_req %b want 1 %b", req_ready, ram_req, exp_req); end
      vectors++; if (ram_addr !== 7'd0) begin miscompares++; $display("FAIL range_addr: got %h want 00", ram_addr); end
      next_cycle();
      drive_idle();
      next_cycle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data || rsp_err !== exp_err) begin miscompares++; $display("FAIL range_rsp: got %b %h %b want 1 %h %b", rsp_valid, rsp_rdata, rsp_err, exp_data, exp_err); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      drive_req(1'b0, 16'd1, 32'h0, 4'h0);
      next_cycle();
      drive_req(1'b0, 16'd2, 32'h0, 4'h0);
      next_cycle();
      drive_idle();
      next_cycle();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0001) begin miscompares++; $display("FAIL mid_queued: got %b %h want 1 cafe0001", rsp_valid, rsp_rdata); end
      next_cycle();
      drive_req(1'b0, 16'd0, 32'h0, 4'h0);
      rst_n = 1'b0;
      #1;
      vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ram_req !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got valid %b ready %b ram_req %b want 0 0 0", rsp_valid, req_ready, ram_req); end
      next_cycle();
      drive_idle(); rsp_ready = 1'b1; rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %b want 1", req_ready); end
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale[%0d]: got valid %b want 0", c, rsp_valid); end
         next_cycle();
      end
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      drive_idle();
      test_reset();
      test_write_read();
      test_byte_enable();
      test_fill();
      test_stream();
      test_backpressure();
      test_range();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
